// File: rtl/lattuino_rst_sup.sv
// lattuino_rst_sup: board reset supervisor with stretched POR, synced sources,
// software reset, watchdog and a sticky cause register on a WISHBONE port.
module lattuino_rst_sup #(
  parameter int         NUM_SRC      = 1,
  parameter logic [7:0] SRC_FALL     = 8'h01,
  parameter int         SYNC_STAGES  = 2,
  parameter int         POR_CYCLES   = 16,
  parameter int         PULSE_CYCLES = 8,
  parameter int         WDT_W        = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [1:0]         wb_adr_i,
  input  logic [7:0]         wb_dat_i,
  output logic [7:0]         wb_dat_o,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  output logic               wb_ack_o,
  output logic               rst_o
);

  localparam int MAXC = (POR_CYCLES > PULSE_CYCLES) ?
                        POR_CYCLES : PULSE_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int MW = (NUM_SRC < 4) ? NUM_SRC : 4;
  localparam logic [CW-1:0] POR_LD   = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [NUM_SRC-1:0] IDLE = SRC_FALL[NUM_SRC-1:0];

  typedef enum logic [1:0] {
    S_POR,
    S_RUN,
    S_PULSE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rst_q, rst_d;
  logic [3:0]        cause_q, cause_d;
  logic [MW-1:0]     mask_q;
  logic [7:0]        wtop_q;
  logic              wde_q;
  logic [WDT_W-1:0]  wdt_q, wdt_top;
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] hist_q, sync_o, edge_v, mask_ext;
  logic              wr, wr_ctrl, wr_wtop, kick, wr_cause;
  logic              src_hit, sw_hit, wdt_hit;
  logic [7:0]        ctrl_rd;

  assign wb_ack_o = wb_stb_i;
  assign rst_o    = rst_q;

  assign wr       = wb_stb_i & wb_we_i;
  assign wr_ctrl  = wr & (wb_adr_i == 2'd0);
  assign wr_wtop  = wr & (wb_adr_i == 2'd1);
  assign kick     = wr & (wb_adr_i == 2'd2);
  assign wr_cause = wr & (wb_adr_i == 2'd3);

  // Sources past the fourth have no MASK bit and are always live
  always_comb begin
    mask_ext = '0;
    mask_ext[MW-1:0] = mask_q;
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign edge_v = (IDLE & hist_q & ~sync_o) |
                  (~IDLE & ~hist_q & sync_o);
  assign src_hit = (|(edge_v & ~mask_ext)) && (state_q != S_POR);

  always_comb begin
    wdt_top = '1;
    wdt_top[WDT_W-1 -: 8] = wtop_q;
  end

  assign wdt_hit = wde_q & ~rst_q & ~kick & (wdt_q == wdt_top);
  assign sw_hit  = wr_ctrl & wb_dat_i[1] & ~rst_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IDLE;
      hist_q <= IDLE;
    end else begin
      sync_q[0] <= src_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_o;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    unique case (state_q)
      S_POR: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
          rst_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (src_hit || sw_hit || wdt_hit) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LD;
          rst_d   = 1'b1;
        end
      end
      S_PULSE: begin
        if (src_hit) begin
          cnt_d = PULSE_LD;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
          rst_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_POR;
        cnt_d   = POR_LD;
        rst_d   = 1'b1;
      end
    endcase
  end

  // New causes win over a same-cycle write-1-to-clear
  always_comb begin
    cause_d = cause_q;
    if (wr_cause) cause_d = cause_d & ~wb_dat_i[3:0];
    cause_d = cause_d | {wdt_hit, sw_hit, src_hit, 1'b0};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_POR;
      cnt_q   <= POR_LD;
      rst_q   <= 1'b1;
      cause_q <= 4'b0001;
      mask_q  <= '0;
      wtop_q  <= 8'hFF;
      wde_q   <= 1'b0;
      wdt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      cause_q <= cause_d;
      if (wr_ctrl) mask_q <= wb_dat_i[4 +: MW];
      if (wr_wtop) wtop_q <= wb_dat_i;
      if (rst_q) wde_q <= 1'b0;
      else if (wr_ctrl) wde_q <= wb_dat_i[0];
      if (rst_q || kick || wdt_hit) wdt_q <= '0;
      else if (wde_q) wdt_q <= wdt_q + 1'b1;
    end
  end

  always_comb begin
    ctrl_rd = '0;
    ctrl_rd[0] = wde_q;
    ctrl_rd[4 +: MW] = mask_q;
    wb_dat_o = '0;
    unique case (wb_adr_i)
      2'd0: wb_dat_o = ctrl_rd;
      2'd1: wb_dat_o = wtop_q;
      2'd2: wb_dat_o = '0;
      2'd3: wb_dat_o = {4'b0, cause_q};
      default: wb_dat_o = '0;
    endcase
  end

endmodule

// File: tb/tb_lattuino_rst_sup.sv
// Directed bench for lattuino_rst_sup: POR, sources, mask, polarity,
// retrigger, software reset, watchdog and async reset mid-pulse.
`timescale 1ns/1ps
module tb_lattuino_rst_sup;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] src = 2'b01;
  logic [1:0] adr = '0;
  logic [7:0] dat_w = '0;
  logic [7:0] dat_r;
  logic       we = 1'b0;
  logic       stb = 1'b0;
  logic       ack;
  logic       rst;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lattuino_rst_sup #(
    .NUM_SRC(2),
    .SRC_FALL(8'h01),
    .SYNC_STAGES(2),
    .POR_CYCLES(16),
    .PULSE_CYCLES(8),
    .WDT_W(8)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .src_i(src),
    .wb_adr_i(adr),
    .wb_dat_i(dat_w),
    .wb_dat_o(dat_r),
    .wb_we_i(we),
    .wb_stb_i(stb),
    .wb_ack_o(ack),
    .rst_o(rst)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [7:0] d);
    adr = a; dat_w = d; we = 1'b1; stb = 1'b1;
    tick();
    we = 1'b0; stb = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a,
                        input logic [7:0] exp);
    logic [7:0] d;
    adr = a; we = 1'b0; stb = 1'b1;
    #1;
    d = dat_r;
    stb = 1'b0;
    check(tag, {24'h0, d}, {24'h0, exp});
  endtask

  // Edge-indexed observation of rst_o; optional re-fire of src[0]
  task automatic watch(input int n, input bit retrig,
                       output int rise_at, output int fall_at,
                       output int rises);
    logic prev;
    prev = rst;
    rise_at = -1; fall_at = -1; rises = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (retrig && k == 3) src[0] = 1'b1;
      if (retrig && k == 5) src[0] = 1'b0;
      if (rst && !prev) begin
        rises++;
        if (rise_at < 0) rise_at = k;
      end
      if (!rst && prev && fall_at < 0) fall_at = k;
      prev = rst;
    end
  endtask

  task automatic por_len(input string tag);
    int k;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!rst) begin
        k = i;
        break;
      end
    end
    check(tag, k, 16);
  endtask

  int  r, f, nr;
  bit  seen;

  initial begin
    repeat (3) tick();
    check("rst_in_reset", rst, 1);
    stb = 1'b1; #1;
    check("ack_hi", ack, 1);
    stb = 1'b0; #1;
    check("ack_lo", ack, 0);
    rd_chk("ctrl_rst", 2'd0, 8'h00);
    rd_chk("wtop_rst", 2'd1, 8'hFF);
    rd_chk("cause_rst", 2'd3, 8'h01);
    rst_n = 1'b1;
    por_len("por_len");
    rd_chk("cause_por", 2'd3, 8'h01);
    rd_chk("kick_rd", 2'd2, 8'h00);

    // falling-edge source, like FTDI DTR
    src[0] = 1'b0;
    watch(20, 1'b0, r, f, nr);
    check("dtr_rise", r, 3);
    check("dtr_fall", f, 11);
    check("dtr_rises", nr, 1);
    rd_chk("dtr_cause", 2'd3, 8'h03);
    wb_wr(2'd3, 8'h03);
    rd_chk("cause_clr", 2'd3, 8'h00);
    src[0] = 1'b1;
    watch(6, 1'b0, r, f, nr);
    check("dtr_release", nr, 0);

    // mask readback and masked source
    wb_wr(2'd0, 8'hF0);
    rd_chk("mask_rd", 2'd0, 8'h30);
    src[0] = 1'b0;
    watch(12, 1'b0, r, f, nr);
    check("mask_block", nr, 0);
    src[0] = 1'b1;
    repeat (4) tick();
    wb_wr(2'd0, 8'h00);
    rd_chk("mask_off", 2'd0, 8'h00);

    // rising-edge source
    src[1] = 1'b1;
    watch(20, 1'b0, r, f, nr);
    check("rise_src_rise", r, 3);
    check("rise_src_fall", f, 11);
    rd_chk("rise_src_cause", 2'd3, 8'h02);
    wb_wr(2'd3, 8'h0F);
    src[1] = 1'b0;
    watch(12, 1'b0, r, f, nr);
    check("rise_src_fall_ign", nr, 0);

    // retrigger inside a pulse
    src[0] = 1'b0;
    watch(30, 1'b1, r, f, nr);
    check("retrig_rise", r, 3);
    check("retrig_fall", f, 16);
    check("retrig_rises", nr, 1);
    rd_chk("retrig_cause", 2'd3, 8'h02);
    src[0] = 1'b1;
    repeat (4) tick();
    wb_wr(2'd3, 8'h0F);

    // software reset, mask kept through rst_o
    wb_wr(2'd0, 8'h12);
    check("sw_rise", rst, 1);
    watch(12, 1'b0, r, f, nr);
    check("sw_fall", f, 8);
    check("sw_rises", nr, 0);
    rd_chk("sw_cause", 2'd3, 8'h04);
    rd_chk("sw_ctrl", 2'd0, 8'h10);
    wb_wr(2'd0, 8'h00);
    wb_wr(2'd3, 8'h0F);

    // watchdog timeout
    wb_wr(2'd1, 8'h10);
    rd_chk("wtop_rd", 2'd1, 8'h10);
    wb_wr(2'd0, 8'h01);
    watch(30, 1'b0, r, f, nr);
    check("wdt_rise", r, 17);
    check("wdt_fall", f, 25);
    rd_chk("wdt_cause", 2'd3, 8'h08);
    rd_chk("wdt_wde_off", 2'd0, 8'h00);
    rd_chk("wdt_wtop_kept", 2'd1, 8'h10);
    wb_wr(2'd3, 8'h0F);

    // watchdog kept alive by kicks
    wb_wr(2'd0, 8'h01);
    seen = 1'b0;
    for (int j = 0; j < 6; j++) begin
      for (int m = 0; m < 9; m++) begin
        tick();
        if (rst) seen = 1'b1;
      end
      wb_wr(2'd2, 8'h00);
      if (rst) seen = 1'b1;
    end
    check("kick_noreset", seen, 0);
    rd_chk("kick_wde_on", 2'd0, 8'h01);
    rd_chk("kick_cause", 2'd3, 8'h00);
    wb_wr(2'd0, 8'h00);

    // software reset coincident with a source event
    src[0] = 1'b0;
    tick();
    tick();
    wb_wr(2'd0, 8'h02);
    check("sim_rise", rst, 1);
    watch(12, 1'b0, r, f, nr);
    check("sim_fall", f, 8);
    check("sim_rises", nr, 0);
    rd_chk("sim_cause", 2'd3, 8'h06);
    src[0] = 1'b1;
    repeat (4) tick();
    wb_wr(2'd3, 8'h0F);

    // async reset in the middle of a pulse
    wb_wr(2'd0, 8'h02);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("async_rst", rst, 1);
    rd_chk("async_cause", 2'd3, 8'h01);
    rd_chk("async_wtop", 2'd1, 8'hFF);
    rd_chk("async_ctrl", 2'd0, 8'h00);
    rst_n = 1'b1;
    por_len("por_len2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
